axi_tx_channel: RTL



---
 rtl/axi_tx_channel.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/axi_tx_channel.sv
// Purpose : transmit-side VALID/READY channel stage. Words from the upper module
//           are queued in a DEPTH-entry FIFO and presented one at a time from a
//           registered output stage (VALID/xDATA). When the FIFO is empty and the
//           output register is free, a pushed word bypasses the FIFO.
// Latency : push at edge N -> VALID=1 after edge N (bypass); one transfer per cycle sustained.
// Backpr. : VALID is held with stable xDATA until READY; pushes while tx_full are dropped.
// Ports   : ACLK/ARESETn (async active-low); tx_data/tx_push/tx_full/tx_empty/tx_level
//           toward the upper module; VALID/xDATA/READY toward the link.
// Option  : define AXI_TX_STALL_CNT_EN to add stall_cnt[15:0] (cycles with VALID && !READY).
module axi_tx_channel #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic [WIDTH-1:0]              tx_data,
  input  logic                          tx_push,
  output logic                          tx_full,
  output logic                          tx_empty,
  output logic [$clog2(DEPTH+2)-1:0]    tx_level,
  output logic                          VALID,
  input  logic                          READY,
  output logic [WIDTH-1:0]              xDATA
`ifdef AXI_TX_STALL_CNT_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+2);

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  out_state_t       state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    count;

  logic             fifo_empty;
  logic             out_free;
  logic             push_ok;
  logic             bypass;
  logic             pop;
  logic             wr;
  logic             valid_nxt;
  logic [LW-1:0]    count_nxt;

  // Status decoded from the registered count at the start of the cycle.
  assign fifo_empty = (count == '0);
  assign tx_full    = (count == LW'(DEPTH));
  assign tx_empty   = fifo_empty && !VALID;

  // Output register can take a new word if it is empty or draining this edge.
  assign out_free   = !VALID || READY;
  // A push seen while full is dropped even if a pop frees a slot this cycle.
  assign push_ok    = tx_push && !tx_full;
  // Bypass only with an empty FIFO, so ordering is always preserved.
  assign bypass     = push_ok && fifo_empty && out_free;
  assign pop        = !fifo_empty && out_free;
  assign wr         = push_ok && !bypass;

  always_comb begin
    count_nxt = count;
    if (wr && !pop) begin
      count_nxt = count + LW'(1);
    end else if (!wr && pop) begin
      count_nxt = count - LW'(1);
    end
    valid_nxt = out_free ? (pop || bypass) : 1'b1;
  end

  // Storage carries no reset; only the pointers and count qualify its contents.
  always_ff @(posedge ACLK) begin
    if (wr) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // Output stage FSM, pointers, count and level, all on the same edge.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= OUT_EMPTY;
      VALID    <= 1'b0;
      xDATA    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_level <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count    <= count_nxt;
      tx_level <= count_nxt + LW'(valid_nxt);

      case (state)
        OUT_EMPTY: begin
          if (pop) begin
            xDATA <= mem[rd_ptr];
            state <= OUT_FULL;
            VALID <= 1'b1;
          end else if (bypass) begin
            xDATA <= tx_data;
            state <= OUT_FULL;
            VALID <= 1'b1;
          end
        end
        OUT_FULL: begin
          if (READY) begin
            // Handshake: reload back-to-back if anything is available,
            // otherwise go idle. xDATA keeps its last value when idle.
            if (pop) begin
              xDATA <= mem[rd_ptr];
            end else if (bypass) begin
              xDATA <= tx_data;
            end else begin
              state <= OUT_EMPTY;
              VALID <= 1'b0;
            end
          end
        end
        default: begin
          state <= OUT_EMPTY;
          VALID <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXI_TX_STALL_CNT_EN
  // Counts stalled cycles of the current word; cleared by its handshake.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      stall_cnt <= '0;
    end else if (VALID && READY) begin
      stall_cnt <= '0;
    end else if (VALID && !READY && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
